// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding used by the ALU and the control decoder.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SLT   = 3'b101,
    ALU_SLTU  = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_adder.sv
// Shared add/subtract unit: sum = a + (sub ? ~b : b) + sub, with carry-out and signed overflow.
module alu_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_full;

  assign w_b_eff = sub ? ~b : b;
  assign w_full  = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, sub};
  assign sum     = w_full[WIDTH-1:0];
  assign carry   = w_full[WIDTH];
  // Overflow: operands share a sign that the result does not.
  assign ovf     = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_core.sv
// RV32I integer ALU: combinational result and flags, plus a registered result/zero tap.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] rslt,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic [WIDTH-1:0] rslt_q,
  output logic             zero_q
);

  alu_op_e          w_op;
  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_ovf;
  logic             w_adder_op;
  logic [WIDTH-1:0] r_rslt_q;
  logic             r_zero_q;

  assign w_op  = alu_op_e'(ALUControl);
  assign w_sub = (w_op == ALU_SUB) || (w_op == ALU_SLT);

  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .a     (a),
    .b     (b),
    .sub   (w_sub),
    .sum   (w_sum),
    .carry (w_carry),
    .ovf   (w_ovf)
  );

  always_comb begin
    rslt = '0;
    case (w_op)
      ALU_ADD,
      ALU_SUB:   rslt = w_sum;
      ALU_AND:   rslt = a & b;
      ALU_OR:    rslt = a | b;
      ALU_XOR:   rslt = a ^ b;
      ALU_SLT:   rslt = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
      ALU_SLTU:  rslt = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_PASSB: rslt = b;
      default:   rslt = '0;
    endcase
  end

  // Flags follow the adder whenever it is doing real work (ADD, SUB, and the SLT compare).
  assign w_adder_op = (w_op == ALU_ADD) || w_sub;
  assign carry      = w_adder_op & w_carry;
  assign ovf        = w_adder_op & w_ovf;
  assign zero       = (rslt == '0);
  assign neg        = rslt[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rslt_q <= '0;
      r_zero_q <= 1'b0;
    end else begin
      r_rslt_q <= rslt;
      r_zero_q <= zero;
    end
  end

  assign rslt_q = r_rslt_q;
  assign zero_q = r_zero_q;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: expected comb and registered results queued at drive time.
module tb_alu_core;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         n;
    logic         c;
    logic         o;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
  } reg_exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic [W-1:0] rslt, rslt_q;
  logic         zero, neg, carry, ovf, zero_q;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t     comb_q[$];
  reg_exp_t reg_q[$];

  always #5 clk = ~clk;

  alu_core #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .ALUControl (op),
    .rslt       (rslt),
    .zero       (zero),
    .neg        (neg),
    .carry      (carry),
    .ovf        (ovf),
    .rslt_q     (rslt_q),
    .zero_q     (zero_q)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model built from plain 33-bit arithmetic and signed compares.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W:0] s;
    e = '0;
    case (o)
      3'b000: begin
        s = {1'b0, x} + {1'b0, y};
        e.r = s[W-1:0];
        e.c = s[W];
        e.o = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      3'b001, 3'b101: begin
        e.r = x - y;
        e.c = (x >= y);
        e.o = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
        if (o == 3'b101) e.r = ($signed(x) < $signed(y)) ? 1 : 0;
      end
      3'b010: e.r = x & y;
      3'b011: e.r = x | y;
      3'b100: e.r = x ^ y;
      3'b110: e.r = (x < y) ? 1 : 0;
      default: e.r = y;
    endcase
    e.z = (e.r == 0);
    e.n = e.r[W-1];
    return e;
  endfunction

  // Drive one vector between edges; check comb outputs, then the registered tap after the edge.
  task automatic vec(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] exp_r, input logic rst_edge);
    exp_t e, g;
    reg_exp_t re, rg;
    e   = model(o, x, y);
    e.r = exp_r;
    e.z = (exp_r == 0);
    e.n = exp_r[W-1];
    op = o; a = x; b = y; rst = rst_edge;
    comb_q.push_back(e);
    re.r = rst_edge ? '0 : exp_r;
    re.z = rst_edge ? 1'b0 : (exp_r == 0);
    reg_q.push_back(re);
    #1;
    g = comb_q.pop_front();
    chk($sformatf("rslt op%0d", o), rslt, g.r);
    chk($sformatf("zero op%0d", o), {31'b0, zero}, {31'b0, g.z});
    chk($sformatf("neg op%0d", o), {31'b0, neg}, {31'b0, g.n});
    chk($sformatf("carry op%0d", o), {31'b0, carry}, {31'b0, g.c});
    chk($sformatf("ovf op%0d", o), {31'b0, ovf}, {31'b0, g.o});
    @(posedge clk);
    #1;
    rg = reg_q.pop_front();
    chk("rslt_q", rslt_q, rg.r);
    chk("zero_q", {31'b0, zero_q}, {31'b0, rg.z});
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; op = 3'b000;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("reset rslt_q", rslt_q, 32'h0);
    chk("reset zero_q", {31'b0, zero_q}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    vec(ALU_ADD, 32'd10, 32'd5, 32'd15, 1'b0);
    vec(ALU_ADD, 32'd1000, 32'd20, 32'd1020, 1'b0);
    vec(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
    chk("wrap carry", {31'b0, carry}, 32'd1);
    vec(ALU_SUB, 32'd10, 32'd3, 32'd7, 1'b0);
    vec(ALU_SUB, 32'd42, 32'd42, 32'd0, 1'b0);
    vec(ALU_SUB, 32'd42, 32'd43, 32'hFFFF_FFFF, 1'b0);
    chk("sub neg", {31'b0, neg}, 32'd1);
    vec(ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0);
    vec(ALU_OR, 32'hF000_0000, 32'h0F00_0000, 32'hFF00_0000, 1'b0);
    vec(ALU_XOR, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1'b0);
    vec(ALU_SLT, 32'd3, 32'd4, 32'd1, 1'b0);
    vec(ALU_SLT, 32'd10, 32'd2, 32'd0, 1'b0);
    vec(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    vec(ALU_SLT, 32'h8000_0000, 32'd1, 32'd1, 1'b0);
    chk("slt ovf", {31'b0, ovf}, 32'd1);
    vec(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    vec(ALU_PASSB, 32'd7, 32'h1234_5000, 32'h1234_5000, 1'b0);

    // Register/reset sequence: result held combinationally while the tap is cleared.
    @(negedge clk);
    vec(ALU_ADD, 32'd10, 32'd5, 32'd15, 1'b0);
    @(negedge clk);
    vec(ALU_ADD, 32'd10, 32'd5, 32'd15, 1'b1);
    chk("rslt during rst", rslt, 32'd15);
    @(negedge clk);
    vec(ALU_ADD, 32'd10, 32'd5, 32'd15, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] rx, ry;
      exp_t         m;
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = (i % 4 == 0) ? rx : $urandom;
      m  = model(ro, rx, ry);
      @(negedge clk);
      vec(ro, rx, ry, m.r, 1'b0);
    end

    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d/%0d entries left", comb_q.size(), reg_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
